// File: rtl/pipe_skid_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_if
//   Valid/ready/data handshake bundle for one side of a pipeline stage.
//   master : drives data and valid, receives ready (the producer).
//   slave  : receives data and valid, drives ready (the consumer).
//   Parameter WIDTH sets the payload width in bits.
// -----------------------------------------------------------------------------
interface pipe_skid_reg_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//   Elastic pipeline register with a one-entry skid buffer. Upstream ready is
//   a flop, so stalls propagate one stage per cycle without combinational
//   ready chains. Holds up to two entries (main + skid), in strict FIFO order.
//
// Ports
//   clk          : rising-edge clock
//   reset        : asynchronous active-high reset
//   flush        : synchronous squash of every held entry
//   in_if        : upstream handshake (slave: data/valid in, ready out)
//   out_if       : downstream handshake (master: data/valid out, ready in);
//                  out_if.data is driven straight from the main register
//   occupancy    : number of held entries (0, 1 or 2)
//   stall_cycles : saturating count of cycles with out valid and not ready
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  pipe_skid_reg_if.slave        in_if,
  pipe_skid_reg_if.master       out_if,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [1:0]       occ_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic acc;
  logic take;

  assign acc  = in_if.valid & in_ready_q;
  assign take = out_valid_q & out_if.ready;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_if.ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Outputs are updated alongside the state so they come straight from flops.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  // NOTE: the data registers are reset (to RESET_VAL) on purpose: out_data is
  // a direct register output and must be defined from reset onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      stall_cnt_q <= '0;
    end else begin
      // The stall counter ignores flush; only reset clears it.
      stall_cnt_q <= stall_cnt_d;

      if (flush) begin
        // A take in this cycle has already completed on the bus; an accept
        // is simply discarded.
        state_q     <= EMPTY;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
        occ_q       <= 2'd0;
        main_q      <= RESET_VAL;
        skid_q      <= RESET_VAL;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (acc) begin
              state_q     <= ONE;
              main_q      <= in_if.data;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b1;
              occ_q       <= 2'd1;
            end
          end

          ONE: begin
            if (acc && take) begin
              main_q <= in_if.data;
            end else if (take) begin
              state_q     <= EMPTY;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              occ_q       <= 2'd0;
            end else if (acc) begin
              // Downstream stalled: park the younger beat in the skid slot
              // and close the upstream door for the next cycle.
              state_q     <= TWO;
              skid_q      <= in_if.data;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              occ_q       <= 2'd2;
            end
          end

          TWO: begin
            // in_ready is low here, so no accept can happen.
            if (take) begin
              state_q     <= ONE;
              main_q      <= skid_q;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b1;
              occ_q       <= 2'd1;
            end
          end

          default: begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd0;
          end
        endcase
      end
    end
  end

  assign in_if.ready   = in_ready_q;
  assign out_if.valid  = out_valid_q;
  assign out_if.data   = main_q;
  assign occupancy     = occ_q;
  assign stall_cycles  = stall_cnt_q;

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised elastic pipeline register that succeeds the single-bit enable flip-flop.
- Built as a WIDTH-bit stage with a valid/ready handshake on both sides, a one-entry skid buffer so in_ready is fully registered, synchronous flush for branch/exception squash, and a saturating back-pressure counter.
- Sits between CPU pipeline stages (e.g. IF/ID, ID/EX) wherever stalls must propagate without combinational ready paths.

Parameters:
- WIDTH, 64, payload width in bits.
- RESET_VAL, 0, value loaded into the main and skid data registers on reset and on flush.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash; discards all held entries.
- in_data  input  WIDTH  payload from the upstream stage.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept; registered.
- out_data  output  WIDTH  payload to the downstream stage; registered, driven directly from the main register.
- out_valid  output  1  out_data is valid; registered.
- out_ready  input  1  downstream accepts.
- occupancy  output  2  number of held entries (0, 1 or 2).
- stall_cycles  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshake terms:
  - Accept (acc) = in_valid & in_ready.
  - Take (take) = out_valid & out_ready.
- Reset (asynchronous, immediate):
  - State EMPTY.
  - out_valid=0, in_ready=1, occupancy=0, stall_cycles=0.
  - Main and skid data = RESET_VAL, so out_data=RESET_VAL.
- States:
  - EMPTY: 0 entries.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Output encoding: out_valid = (state != EMPTY); in_ready = (state != TWO); occupancy follows the state. All are registered.
- Transitions (flush=0):
  - EMPTY: acc -> ONE, main<=in_data. No acc -> hold.
  - ONE: acc & take -> ONE, main<=in_data. take only -> EMPTY. acc only -> TWO, skid<=in_data. Neither -> hold.
  - TWO: acc is impossible because in_ready=0. take -> ONE, main<=skid. No take -> hold.
- Latency: 1 cycle from acc in EMPTY to out_valid=1. Sustained throughput is 1 beat/cycle when out_ready stays high.
- Ordering: strict FIFO; the skid entry is always younger than the main entry.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change. in_valid/in_data are not required to be stable.
- Flush:
  - Highest priority below reset.
  - Next state EMPTY, out_valid<=0, in_ready<=1, main and skid <= RESET_VAL.
  - A take occurring in the flush cycle still counts as delivered. An acc in the flush cycle is dropped.
- stall_cycles:
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Unaffected by flush; cleared only by reset.
- Reset asserted mid-transfer: all entries are lost and outputs return to reset values immediately, without waiting for the clock edge.
- No X propagation: data registers never load while their entry is invalid, except through the flush/reset RESET_VAL load.

Test Plan (WIDTH=8, RESET_VAL=0, CNT_W=4):
- Reset, then stream 0x11,0x22,0x33 with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after accept; occupancy stays 1; in_ready stays 1.
- In ONE with 0xA0 held, drive out_ready=0 and offer 0xA1 -> state TWO, in_ready=0, out_data holds 0xA0. Raise out_ready -> 0xA0 then 0xA1 delivered in order, and in_ready returns to 1 the cycle after the first take.
- Hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cycles counts to 15 and stays at 15; a later flush leaves it at 15.
- In TWO (0x5A, 0x5B held), assert flush with in_valid=1 and in_data=0x77 -> next cycle out_valid=0, occupancy=0, in_ready=1, out_data=0x00; 0x77 never appears at the output.
- Assert reset asynchronously mid-cycle while in ONE -> out_valid drops to 0 and out_data to 0x00 before the next clk edge; stall_cycles=0.
- Random in_valid/out_ready at 50% over 1000 beats -> the output sequence equals the input sequence, with no loss or duplication and no out_data change while out_valid & !out_ready.
